seg_reader: RTL and testbench
=============================

// Module: seg_reader
// PURPOSE
//  Receive side of the two-digit 7-segment display interface. Samples a tens/units
//  segment-pattern pair, waits for the pair to stay stable, then decodes it back to a
//  binary value 0..99. Returns the value to the stopwatch control logic through a
//  valid/ready handshake. Used for display loopback checking and for panel readback.
// PARAMETERS
//  STABLE_CYCLES  4  consecutive cycles a pattern pair must stay unchanged before decode (1..255)
// PORTS
//  clk        in   1  system clock, rising edge
//  nrst       in   1  asynchronous active-low reset
//  seg1_in    in   7  tens-digit pattern, bit0=a .. bit6=g, active-high
//  seg0_in    in   7  units-digit pattern, same bit order
//  num_out    out  8  decoded value tens*10+units, 0..99
//  num_valid  out  1  num_out holds a decoded value
//  num_ready  in   1  consumer accepts num_out this cycle when num_valid=1
//  seg_error  out  1  one-cycle pulse: a stable pair contains an illegal pattern
// BEHAVIOUR
//  Single clock; reset is asynchronous and active-low on nrst.
//  Reset (also mid-operation): state=SETTLE, cnt=0, seg_q=0, num_out=0, num_valid=0, seg_error=0.
//  Every edge: seg_q<={seg1_in,seg0_in}. If inputs!=seg_q then cnt<=0, else cnt<=cnt+1 (saturating).
//  Legal digit codes: 0=0111111 1=0000110 2=1011011 3=1001111 4=1100110 5=1101101
//   6=1111101 7=0000111 8=1111111 9=1100111. Any other code is illegal except blank.
//  Blank = both digits 0000000: not decoded, no error pulse, treated as no display.
//  FSM:
//   SETTLE: wait for cnt==STABLE_CYCLES-1 with inputs==seg_q. Then:
//    both digits legal -> latch num_out, num_valid<=1, save pair to last_q, go HOLD.
//    any illegal digit -> seg_error=1 for one cycle, last_q<=pair, go WAIT_CHG.
//    blank -> last_q<=pair, go WAIT_CHG.
//   HOLD: num_out and num_valid stay stable, and input changes are ignored, until
//    num_valid&&num_ready. On that edge num_valid<=0, go WAIT_CHG.
//   WAIT_CHG: each stable pair is reported at most once. Go SETTLE when seg_q!=last_q.
//    The counter is already running, so the settle time is not extended.
//  Latency: a pair held stable from cycle 0, with no ready stall, gives num_valid on
//   edge STABLE_CYCLES+1. With STABLE_CYCLES=1, num_valid rises on edge 2.
//  num_valid may rise in the same cycle num_ready is already high. The handshake then
//   completes at the next edge, so num_valid is high for exactly one cycle.
//  A glitch shorter than STABLE_CYCLES cycles produces no report and no error.
//  Arithmetic: tens*10 is formed as (t<<3)+(t<<1) in 8 bits. Maximum is 99, so no overflow.
// CONFIGURATION
//  SEG_READER_ERRCNT_EN defined: adds output port err_count [7:0]. It is reset to 0,
//   increments on each seg_error pulse, and saturates at 255.
//  SEG_READER_ERRCNT_EN undefined: port and counter are absent. All other behaviour is identical.
// STRUCTURE
//  Package seg_pkg holds:
//   - typedef seg_t (logic [6:0]);
//   - localparams SEG_D0..SEG_D9 and SEG_BLANK;
//   - typedef enum state_t {SETTLE, HOLD, WAIT_CHG}.
//  Sub-module seg_to_digit is combinational: seg_t in -> logic[3:0] digit, logic legal.
//   It is instantiated twice.
//  Stability counter, FSM, and output registers live in seg_reader.
// TESTING
//  1 seg1=1011011, seg0=0000111 held 10 cycles, ready=1 -> num_out=27, num_valid high
//    on edge 5 (STABLE_CYCLES=4) for 1 cycle.
//  2 Same pair held, ready=0 for 6 cycles then 1 -> num_out=27 stable throughout;
//    exactly one handshake; no second report while the pair is unchanged.
//  3 seg0 toggles 1100111<->1111111 every 2 cycles, then settles at 1100111 with tens 1111111
//    -> no report during toggling; then num_out=89 once.
//  4 seg0=1110111 (illegal) stable -> seg_error one pulse, num_valid stays 0;
//    with SEG_READER_ERRCNT_EN, err_count=1.
//  5 Both digits 0111111 -> num_out=0; then blank pair -> no report, no error;
//    nrst low mid-HOLD -> all outputs 0 asynchronously; a legal pair after release
//    reports normally.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types and constants for the 7-segment readback path.
// Segment bit order is bit0=a .. bit6=g, active-high.
package seg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_D0    = 7'b0111111;
  localparam seg_t SEG_D1    = 7'b0000110;
  localparam seg_t SEG_D2    = 7'b1011011;
  localparam seg_t SEG_D3    = 7'b1001111;
  localparam seg_t SEG_D4    = 7'b1100110;
  localparam seg_t SEG_D5    = 7'b1101101;
  localparam seg_t SEG_D6    = 7'b1111101;
  localparam seg_t SEG_D7    = 7'b0000111;
  localparam seg_t SEG_D8    = 7'b1111111;
  localparam seg_t SEG_D9    = 7'b1100111;
  localparam seg_t SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    SETTLE,
    HOLD,
    WAIT_CHG
  } state_t;

  // tens*10 + units using shifts only; the largest result is 99, so 8 bits suffice
  function automatic logic [7:0] tens_units(input logic [3:0] tens, input logic [3:0] units);
    logic [7:0] t8;
    t8 = {4'b0000, tens};
    return (t8 << 3) + (t8 << 1) + {4'b0000, units};
  endfunction

endpackage

// File: rtl/seg_to_digit.sv
// Combinational decoder: one 7-segment pattern to a BCD digit plus a legality flag.
module seg_to_digit
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       legal
);

  // Map each legal pattern to its digit; anything else is flagged illegal
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    digit = 4'd0;
    legal = 1'b1;
    case (seg)
      SEG_D0:  digit = 4'd0;
      SEG_D1:  digit = 4'd1;
      SEG_D2:  digit = 4'd2;
      SEG_D3:  digit = 4'd3;
      SEG_D4:  digit = 4'd4;
      SEG_D5:  digit = 4'd5;
      SEG_D6:  digit = 4'd6;
      SEG_D7:  digit = 4'd7;
      SEG_D8:  digit = 4'd8;
      SEG_D9:  digit = 4'd9;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_reader.sv
// Two-digit 7-segment readback: debounces the tens/units pattern pair, decodes it to
// 0..99 and hands it out over valid/ready. Each stable pair is reported at most once.
// Optional: define SEG_READER_ERRCNT_EN to add the saturating err_count output.
module seg_reader
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [6:0] seg1_in,
  input  logic [6:0] seg0_in,
  output logic [7:0] num_out,
  output logic       num_valid,
  input  logic       num_ready,
  output logic       seg_error
`ifdef SEG_READER_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

  logic [13:0] pair_in;
  logic [13:0] seg_q;
  logic [13:0] last_q;
  logic [13:0] last_d;
  logic [7:0]  cnt;
  state_t      state;
  state_t      state_d;
  logic [7:0]  num_d;
  logic        valid_d;
  logic        err_d;
  logic [3:0]  dig1;
  logic [3:0]  dig0;
  logic        legal1;
  logic        legal0;
  logic        stable;
  logic        blank;

  assign pair_in = {seg1_in, seg0_in};

  // Counter may run past the threshold while in HOLD; >= keeps SETTLE from stalling then
  assign stable = (pair_in == seg_q) && (cnt >= STABLE_LAST);
  assign blank  = (seg_q == {SEG_BLANK, SEG_BLANK});

  seg_to_digit u_tens (
    .seg   (seg_q[13:7]),
    .digit (dig1),
    .legal (legal1)
  );

  seg_to_digit u_units (
    .seg   (seg_q[6:0]),
    .digit (dig0),
    .legal (legal0)
  );

  // Sample the pattern pair and count how long it has stayed unchanged
  always_ff @(posedge clk or negedge nrst) begin
    // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
    if (!nrst) begin
      seg_q <= '0;
      cnt   <= '0;
    end else begin
      seg_q <= pair_in;
      if (pair_in != seg_q) begin
        cnt <= '0;
      end else if (cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

  // FSM state and output registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= SETTLE;
      num_out   <= '0;
      num_valid <= 1'b0;
      seg_error <= 1'b0;
      last_q    <= '0;
    end else begin
      state     <= state_d;
      num_out   <= num_d;
      num_valid <= valid_d;
      seg_error <= err_d;
      last_q    <= last_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state;
    num_d   = num_out;
    valid_d = num_valid;
    err_d   = 1'b0;
    last_d  = last_q;
    case (state)
      SETTLE: begin
        if (stable) begin
          last_d = seg_q;
          if (blank) begin
            state_d = WAIT_CHG;
          end else if (legal1 && legal0) begin
            num_d   = tens_units(dig1, dig0);
            valid_d = 1'b1;
            state_d = HOLD;
          end else begin
            err_d   = 1'b1;
            state_d = WAIT_CHG;
          end
        end
      end
      HOLD: begin
        if (num_valid && num_ready) begin
          valid_d = 1'b0;
          state_d = WAIT_CHG;
        end
      end
      WAIT_CHG: begin
        if (seg_q != last_q) begin
          state_d = SETTLE;
        end
      end
      default: state_d = SETTLE;
    endcase
  end

`ifdef SEG_READER_ERRCNT_EN
  // Saturating count of illegal-pattern pulses
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_count <= '0;
    end else if (seg_error && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seg_reader.sv
// Scoreboard bench for seg_reader: stimulus pushes expected values, a negedge monitor
// pops and compares on every handshake and tracks seg_error pulses.
module tb_seg_reader;
  import seg_pkg::*;

  logic       clk = 1'b0;
  logic       nrst;
  logic [6:0] seg1;
  logic [6:0] seg0;
  logic [7:0] num_out;
  logic       num_valid;
  logic       num_ready;
  logic       seg_error;
`ifdef SEG_READER_ERRCNT_EN
  logic [7:0] err_count;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int exp_q[$];
  int hs_exp = 0;
  int hs_seen = 0;
  int exp_err = 0;
  int err_seen = 0;

  always #5 clk = ~clk;

  seg_reader #(.STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .seg1_in   (seg1),
    .seg0_in   (seg0),
    .num_out   (num_out),
    .num_valid (num_valid),
    .num_ready (num_ready),
    .seg_error (seg_error)
`ifdef SEG_READER_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // advance n rising edges, then settle 2 time units past the edge before driving
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20; i++) begin
      if (num_valid) break;
      step(1);
    end
    check(name, num_valid, 1);
  endtask

  // Monitor: compare each handshake with the scoreboard, check hold stability and error pulses
  logic       hold_active = 1'b0;
  logic [7:0] hold_val = '0;
  logic       err_prev = 1'b0;
  always @(negedge clk) begin
    if (nrst) begin
      if (num_valid) begin
        if (hold_active) check("hold_stable", num_out, hold_val);
        hold_val = num_out;
        if (num_ready) begin
          hold_active = 1'b0;
          hs_seen++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_report: num_out=%0d, required no report", num_out);
          end else begin
            check("report_value", num_out, exp_q.pop_front());
          end
        end else begin
          hold_active = 1'b1;
        end
      end else begin
        hold_active = 1'b0;
      end
      if (seg_error) begin
        err_seen++;
        check("err_without_valid", num_valid, 0);
        if (err_prev) begin
          n_cmp++;
          n_bad++;
          $display("FAIL err_pulse_width: seg_error high 2+ cycles, required 1");
        end
      end
      err_prev = seg_error;
    end else begin
      hold_active = 1'b0;
      err_prev    = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    nrst      = 1'b0;
    seg1      = SEG_BLANK;
    seg0      = SEG_BLANK;
    num_ready = 1'b0;
    #12;
    check("rst_num_out", num_out, 0);
    check("rst_num_valid", num_valid, 0);
    check("rst_seg_error", seg_error, 0);
`ifdef SEG_READER_ERRCNT_EN
    check("rst_err_count", err_count, 0);
`endif
    @(posedge clk);
    #2;
    nrst = 1'b1;
    step(8);

    // 1: 27 held with ready high; valid exactly on edge 5 for one cycle
    num_ready = 1'b1;
    exp_q.push_back(27);
    hs_exp++;
    seg1 = SEG_D2;
    seg0 = SEG_D7;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("t1_valid_edge%0d", k), num_valid, (k == 5) ? 1 : 0);
      #1;
    end
    step(4);

    // 2: re-present 27 after a blank, stall ready for 6 cycles
    seg1 = SEG_BLANK;
    seg0 = SEG_BLANK;
    step(8);
    num_ready = 1'b0;
    exp_q.push_back(27);
    hs_exp++;
    seg1 = SEG_D2;
    seg0 = SEG_D7;
    wait_valid("t2_valid_timeout");
    step(6);
    check("t2_still_valid", num_valid, 1);
    check("t2_value_in_hold", num_out, 27);
    num_ready = 1'b1;
    step(12);
    check("t2_no_rereport", num_valid, 0);

    // 3: units toggles 9/8 every 2 cycles, then settles at 9 -> single 89
    exp_q.push_back(89);
    hs_exp++;
    seg1 = SEG_D8;
    for (int i = 0; i < 6; i++) begin
      seg0 = (i % 2 == 0) ? SEG_D9 : SEG_D8;
      step(2);
    end
    seg0 = SEG_D9;
    step(12);

    // 4: illegal units pattern -> one error pulse, no report
    exp_err++;
    seg1 = SEG_D1;
    seg0 = 7'b1110111;
    step(10);
    check("t4_err_pulses", err_seen, exp_err);
    check("t4_no_valid", num_valid, 0);
`ifdef SEG_READER_ERRCNT_EN
    check("t4_err_count", err_count, 1);
`endif

    // 5: 00, then blank (silent), then reset mid-HOLD, then 63
    exp_q.push_back(0);
    hs_exp++;
    seg1 = SEG_D0;
    seg0 = SEG_D0;
    step(10);
    seg1 = SEG_BLANK;
    seg0 = SEG_BLANK;
    step(10);
    check("t5_handshakes", hs_seen, hs_exp);
    check("t5_err_pulses", err_seen, exp_err);
    num_ready = 1'b0;
    seg1 = SEG_D4;
    seg0 = SEG_D5;
    wait_valid("t5_valid_timeout");
    step(2);
    check("t5_hold_value", num_out, 45);
    #1;
    nrst = 1'b0;
    #1;
    check("t5_rst_num_out", num_out, 0);
    check("t5_rst_num_valid", num_valid, 0);
    check("t5_rst_seg_error", seg_error, 0);
`ifdef SEG_READER_ERRCNT_EN
    check("t5_rst_err_count", err_count, 0);
`endif
    seg1 = SEG_BLANK;
    seg0 = SEG_BLANK;
    step(2);
    nrst = 1'b1;
    step(1);
    num_ready = 1'b1;
    exp_q.push_back(63);
    hs_exp++;
    seg1 = SEG_D6;
    seg0 = SEG_D3;
    step(12);

    check("final_scoreboard_drained", exp_q.size(), 0);
    check("final_handshakes", hs_seen, hs_exp);
    check("final_err_pulses", err_seen, exp_err);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
